// File: rtl/digital_clock_top.sv
// 24-hour HH:MM:SS clock: prescaler to a one-second tick, cascaded BCD digit
// registers, and one 7-segment decoder per digit (active-high, seg[0]=a).

module digital_clock_seg7 (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // BCD digit to active-high segment pattern; anything else blanks
    always_comb begin
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end

endmodule

module digital_clock_top #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] seg_sec_unit,
    output logic [6:0] seg_sec_tens,
    output logic [6:0] seg_min_unit,
    output logic [6:0] seg_min_tens,
    output logic [6:0] seg_hour_unit,
    output logic [6:0] seg_hour_tens
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q, count_d;
    logic          tick_s;

    logic [3:0] sec_unit_q,  sec_unit_d;
    logic [3:0] sec_tens_q,  sec_tens_d;
    logic [3:0] min_unit_q,  min_unit_d;
    logic [3:0] min_tens_q,  min_tens_d;
    logic [3:0] hour_unit_q, hour_unit_d;
    logic [3:0] hour_tens_q, hour_tens_d;

    // Prescaler: tick is high during the last count so digits advance on the wrap edge
    always_comb begin
        tick_s = (count_q == LAST);
        if (tick_s) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    // Cascaded BCD increment; every carry resolves within the tick cycle
    always_comb begin
        sec_unit_d  = sec_unit_q;
        sec_tens_d  = sec_tens_q;
        min_unit_d  = min_unit_q;
        min_tens_d  = min_tens_q;
        hour_unit_d = hour_unit_q;
        hour_tens_d = hour_tens_q;
        if (tick_s) begin
            if (sec_unit_q == 4'd9) begin
                sec_unit_d = 4'd0;
                if (sec_tens_q == 4'd5) begin
                    sec_tens_d = 4'd0;
                    if (min_unit_q == 4'd9) begin
                        min_unit_d = 4'd0;
                        if (min_tens_q == 4'd5) begin
                            min_tens_d = 4'd0;
                            // 23 wraps to 00 before the generic units carry applies
                            if ((hour_tens_q == 4'd2) && (hour_unit_q == 4'd3)) begin
                                hour_tens_d = 4'd0;
                                hour_unit_d = 4'd0;
                            end else if (hour_unit_q == 4'd9) begin
                                hour_unit_d = 4'd0;
                                hour_tens_d = hour_tens_q + 4'd1;
                            end else begin
                                hour_unit_d = hour_unit_q + 4'd1;
                            end
                        end else begin
                            min_tens_d = min_tens_q + 4'd1;
                        end
                    end else begin
                        min_unit_d = min_unit_q + 4'd1;
                    end
                end else begin
                    sec_tens_d = sec_tens_q + 4'd1;
                end
            end else begin
                sec_unit_d = sec_unit_q + 4'd1;
            end
        end else begin
            sec_unit_d = sec_unit_q;
        end
    end

    // State registers with asynchronous reset to 00:00:00 and a fresh prescaler
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            sec_unit_q  <= 4'd0;
            sec_tens_q  <= 4'd0;
            min_unit_q  <= 4'd0;
            min_tens_q  <= 4'd0;
            hour_unit_q <= 4'd0;
            hour_tens_q <= 4'd0;
        end else begin
            count_q     <= count_d;
            sec_unit_q  <= sec_unit_d;
            sec_tens_q  <= sec_tens_d;
            min_unit_q  <= min_unit_d;
            min_tens_q  <= min_tens_d;
            hour_unit_q <= hour_unit_d;
            hour_tens_q <= hour_tens_d;
        end
    end

    digital_clock_seg7 u_seg_sec_unit  (.digit(sec_unit_q),  .seg(seg_sec_unit));
    digital_clock_seg7 u_seg_sec_tens  (.digit(sec_tens_q),  .seg(seg_sec_tens));
    digital_clock_seg7 u_seg_min_unit  (.digit(min_unit_q),  .seg(seg_min_unit));
    digital_clock_seg7 u_seg_min_tens  (.digit(min_tens_q),  .seg(seg_min_tens));
    digital_clock_seg7 u_seg_hour_unit (.digit(hour_unit_q), .seg(seg_hour_unit));
    digital_clock_seg7 u_seg_hour_tens (.digit(hour_tens_q), .seg(seg_hour_tens));

endmodule

// File: tb/tb_digital_clock_top.sv
// Directed bench for digital_clock_top with TICK_DIV=4; expected displays come
// from a bench-side digit-code table. Near-midnight states are preloaded by force.

module tb_digital_clock_top;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] seg_sec_unit, seg_sec_tens, seg_min_unit, seg_min_tens;
    logic [6:0] seg_hour_unit, seg_hour_tens;
    logic [41:0] disp;

    int vectors    = 0;
    int miscompares = 0;

    digital_clock_top #(.TICK_DIV(TD)) dut (
        .clk          (clk),
        .rst          (rst),
        .seg_sec_unit (seg_sec_unit),
        .seg_sec_tens (seg_sec_tens),
        .seg_min_unit (seg_min_unit),
        .seg_min_tens (seg_min_tens),
        .seg_hour_unit(seg_hour_unit),
        .seg_hour_tens(seg_hour_tens)
    );

    assign disp = {seg_hour_tens, seg_hour_unit, seg_min_tens, seg_min_unit,
                   seg_sec_tens, seg_sec_unit};

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_code(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [41:0] exp_disp(input int h, input int m, input int s);
        return {seg_code(h / 10), seg_code(h % 10), seg_code(m / 10), seg_code(m % 10),
                seg_code(s / 10), seg_code(s % 10)};
    endfunction

    task automatic wait_ticks(input int n);
        repeat (n * TD) @(posedge clk);
        #1;
    endtask

    // Called just after a tick edge; loads digits, then runs to the next tick
    task automatic preload(input logic [3:0] ht, input logic [3:0] hu, input logic [3:0] mt,
                           input logic [3:0] mu, input logic [3:0] st, input logic [3:0] su);
        @(negedge clk);
        force dut.hour_tens_q = ht;
        force dut.hour_unit_q = hu;
        force dut.min_tens_q  = mt;
        force dut.min_unit_q  = mu;
        force dut.sec_tens_q  = st;
        force dut.sec_unit_q  = su;
        @(posedge clk);
        @(negedge clk);
        release dut.hour_tens_q;
        release dut.hour_unit_q;
        release dut.min_tens_q;
        release dut.min_unit_q;
        release dut.sec_tens_q;
        release dut.sec_unit_q;
        repeat (TD - 1) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #10;
            if (disp !== exp_disp(0, 0, 0)) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, disp, exp_disp(0, 0, 0));
            end
            vectors++;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e < TD; e++) begin
            @(posedge clk);
            #1;
            if (disp !== exp_disp(0, 0, 0)) begin
                miscompares++;
                $display("FAIL reset_release_edge%0d: got %h expected %h", e, disp, exp_disp(0, 0, 0));
            end
            vectors++;
        end
    endtask

    task automatic test_first_tick;
        @(posedge clk);
        #1;
        if (disp !== exp_disp(0, 0, 1)) begin
            miscompares++;
            $display("FAIL first_tick: got %h expected %h", disp, exp_disp(0, 0, 1));
        end
        vectors++;
        wait_ticks(1);
        if (disp !== exp_disp(0, 0, 2)) begin
            miscompares++;
            $display("FAIL second_tick: got %h expected %h", disp, exp_disp(0, 0, 2));
        end
        vectors++;
    endtask

    task automatic test_minute_rollover;
        wait_ticks(57);
        if (disp !== exp_disp(0, 0, 59)) begin
            miscompares++;
            $display("FAIL at_59s: got %h expected %h", disp, exp_disp(0, 0, 59));
        end
        vectors++;
        wait_ticks(1);
        if (disp !== exp_disp(0, 1, 0)) begin
            miscompares++;
            $display("FAIL minute_carry: got %h expected %h", disp, exp_disp(0, 1, 0));
        end
        vectors++;
        wait_ticks(10);
        if (disp !== exp_disp(0, 1, 10)) begin
            miscompares++;
            $display("FAIL at_1m10s: got %h expected %h", disp, exp_disp(0, 1, 10));
        end
        vectors++;
    endtask

    task automatic test_hour_carry;
        wait_ticks(3529);
        if (disp !== exp_disp(0, 59, 59)) begin
            miscompares++;
            $display("FAIL at_59m59s: got %h expected %h", disp, exp_disp(0, 59, 59));
        end
        vectors++;
        wait_ticks(1);
        if (disp !== exp_disp(1, 0, 0)) begin
            miscompares++;
            $display("FAIL hour_carry: got %h expected %h", disp, exp_disp(1, 0, 0));
        end
        vectors++;
    endtask

    task automatic test_day_wrap;
        preload(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd8);
        if (disp !== exp_disp(23, 59, 59)) begin
            miscompares++;
            $display("FAIL at_23_59_59: got %h expected %h", disp, exp_disp(23, 59, 59));
        end
        vectors++;
        wait_ticks(1);
        if (disp !== exp_disp(0, 0, 0)) begin
            miscompares++;
            $display("FAIL day_wrap: got %h expected %h", disp, exp_disp(0, 0, 0));
        end
        vectors++;
        preload(4'd0, 4'd9, 4'd5, 4'd9, 4'd5, 4'd8);
        if (disp !== exp_disp(9, 59, 59)) begin
            miscompares++;
            $display("FAIL at_09_59_59: got %h expected %h", disp, exp_disp(9, 59, 59));
        end
        vectors++;
        wait_ticks(1);
        if (disp !== exp_disp(10, 0, 0)) begin
            miscompares++;
            $display("FAIL hour_9_to_10: got %h expected %h", disp, exp_disp(10, 0, 0));
        end
        vectors++;
        preload(4'd1, 4'd9, 4'd5, 4'd9, 4'd5, 4'd8);
        wait_ticks(1);
        if (disp !== exp_disp(20, 0, 0)) begin
            miscompares++;
            $display("FAIL hour_19_to_20: got %h expected %h", disp, exp_disp(20, 0, 0));
        end
        vectors++;
        wait_ticks(14);
        if (disp !== exp_disp(20, 0, 14)) begin
            miscompares++;
            $display("FAIL at_20_00_14: got %h expected %h", disp, exp_disp(20, 0, 14));
        end
        vectors++;
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        rst = 1'b1;
        #1;
        if (disp !== exp_disp(0, 0, 0)) begin
            miscompares++;
            $display("FAIL reset_from_20h: got %h expected %h", disp, exp_disp(0, 0, 0));
        end
        vectors++;
        @(negedge clk);
        rst = 1'b0;
        wait_ticks(37);
        if (disp !== exp_disp(0, 0, 37)) begin
            miscompares++;
            $display("FAIL at_37s: got %h expected %h", disp, exp_disp(0, 0, 37));
        end
        vectors++;
        #2 rst = 1'b1;
        #1;
        if (disp !== exp_disp(0, 0, 0)) begin
            miscompares++;
            $display("FAIL async_clear: got %h expected %h", disp, exp_disp(0, 0, 0));
        end
        vectors++;
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e < TD; e++) begin
            @(posedge clk);
            #1;
            if (disp !== exp_disp(0, 0, 0)) begin
                miscompares++;
                $display("FAIL rerelease_edge%0d: got %h expected %h", e, disp, exp_disp(0, 0, 0));
            end
            vectors++;
        end
        @(posedge clk);
        #1;
        if (disp !== exp_disp(0, 0, 1)) begin
            miscompares++;
            $display("FAIL rerelease_first_tick: got %h expected %h", disp, exp_disp(0, 0, 1));
        end
        vectors++;
    endtask

    initial begin
        test_reset;
        test_first_tick;
        test_minute_rollover;
        test_hour_carry;
        test_day_wrap;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/digital_clock_top.md
Name: digital_clock_top

Overview:
- 24-hour real-time clock (HH:MM:SS) driven from one system clock.
- A prescaler divides the system clock to a one-cycle seconds tick. Cascaded BCD counters hold seconds, minutes and hours.
- Each of the six BCD digits is decoded to its own 7-segment output.
- Top-level block wired directly to six display digits; it has no other inputs.

Parameters:
- TICK_DIV, 100_000_000, number of clk cycles per one-second tick (100 MHz clk). Benches override it to a small value (e.g. 4). Legal range is >= 2.

Ports:
- clk  input  1  system clock, rising-edge active (100 MHz nominal, 10 ns period).
- rst  input  1  asynchronous, active-high reset.
- seg_sec_unit  output  7  segments for seconds units digit.
- seg_sec_tens  output  7  segments for seconds tens digit.
- seg_min_unit  output  7  segments for minutes units digit.
- seg_min_tens  output  7  segments for minutes tens digit.
- seg_hour_unit  output  7  segments for hours units digit.
- seg_hour_tens  output  7  segments for hours tens digit.

Behaviour:
- Single clock domain: clk. Reset is asynchronous and active-high (rst).
- While rst=1, all of the following are 0, and all six segment outputs equal 7'h3F ("0"), i.e. display 00:00:00:
  - prescaler count
  - tick
  - the six BCD digit registers
- rst deasserted mid-count: all counting restarts from 00:00:00 with a fresh prescaler.

Prescaler:
- Counter 0..TICK_DIV-1, incrementing every clk.
- At TICK_DIV-1 it returns to 0 and asserts tick for exactly one cycle.
- The first tick is therefore registered on the TICK_DIV-th rising edge after rst release.

Time counters:
- Advance only on the edge where tick=1; one increment per tick.
- sec_unit 0..9. When it wraps 9->0, sec_tens increments.
- sec_tens 0..5. At 59 -> 00 it carries to min_unit.
- min_unit/min_tens follow the same pattern: 59 -> 00 carries to hour.
- Hours are BCD 00..23. hour_unit wraps 9->0 with hour_tens+1, except that 23 -> 00 resets both hour digits.
- Full wrap: 23:59:59 + 1 tick = 00:00:00.
- All carries ripple within the same tick cycle; no extra latency.
- Digit registers never hold illegal values:
  - seconds/minutes tens <= 5
  - hours <= 23
  - units <= 9

7-segment decode:
- Combinational from the digit registers; the display changes in the same cycle the register updates.
- Active-high segments, bit order seg[0]=a, seg[1]=b, ... seg[6]=g.
- Digit codes:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F
- Any other value decodes to 7'h00 (blank). This is unreachable in normal operation.

Implementation:
- Suggested structure: prescaler, seconds/minutes/hours counter submodules, six decoder instances.
- Target 120-400 lines of RTL.

Test Plan:
1. Reset: hold rst=1 for 50 ns, with TICK_DIV=4. Required: all six outputs = 7'h3F throughout, and they stay 3F until the 4th rising edge after release.
2. First tick: TICK_DIV=4, release rst. Required: seg_sec_unit = 7'h06 after the 4th edge, 7'h5B after the 8th; all other digits stay 7'h3F.
3. Seconds/minute rollover: run 60 ticks. Required:
   - At 59 s: sec_tens=6D, sec_unit=6F.
   - On the next tick: 00:01:00, i.e. min_unit=06 and both sec digits=3F.
4. Hour carry: run 3600 ticks. Required: display 01:00:00, i.e. hour_unit=06 and all min/sec digits=3F.
5. Day wrap: run 86399 ticks. Required:
   - Display 23:59:59: hour_tens=5B, hour_unit=4F, min_tens=6D, min_unit=6F, sec_tens=6D, sec_unit=6F.
   - One more tick: all six outputs = 3F.
6. Async reset mid-run: assert rst between clk edges at e.g. 00:00:37. Required:
   - Outputs return to 3F immediately, without waiting for a clk edge.
   - After release, the first increment occurs exactly TICK_DIV edges later.
